// File: rtl/trail_compositor.sv
// trail_compositor
//   Composites the bike sprite layer over the frame-buffer trail layer and
//   checks, once per frame, whether any live bike head lands on a trail.
//
//   Ports
//     Clk, Reset         system clock, asynchronous active-high reset
//     frame_clk          frame tick, asynchronous to Clk (rising edge = frame start)
//     DrawX, DrawY       current pixel coordinates
//     pix_valid          DrawX/DrawY lie in the visible area
//     bike_color_in      sprite enum for the current pixel (TRANSPARENT = none)
//     head_x, head_y     packed bike-head coordinates, player p at [10p+9:10p]
//     player_alive       per-player enable for collision checking
//     blocked            per-player crash flag from game logic
//     rd_addr            frame-buffer read address (combinational)
//     rd_data            frame-buffer word, one Clk after rd_addr
//     color_enum         composited pixel enum, 2 Clk after DrawX
//     pix_valid_out      pix_valid aligned with color_enum
//     collide            per-player collision result of the last completed frame
//     collide_valid      one-Clk pulse when collide is updated
module trail_compositor #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned COLOR_W     = 4,
    parameter logic [COLOR_W-1:0] CRASH_COLOR = 4'h7,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 4'hF,
    parameter logic [COLOR_W-1:0] TRAIL_EMPTY = 4'h0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      pix_valid,
    input  logic [COLOR_W-1:0]        bike_color_in,
    input  logic [NUM_PLAYERS*10-1:0] head_x,
    input  logic [NUM_PLAYERS*10-1:0] head_y,
    input  logic [NUM_PLAYERS-1:0]    player_alive,
    input  logic [NUM_PLAYERS-1:0]    blocked,
    output logic [18:0]               rd_addr,
    input  logic [15:0]               rd_data,
    output logic [COLOR_W-1:0]        color_enum,
    output logic                      pix_valid_out,
    output logic [NUM_PLAYERS-1:0]    collide,
    output logic                      collide_valid
);

    localparam logic [18:0] HALF_LINE = 19'(H_RES / 2);
    localparam logic [9:0]  H_LIM     = 10'(H_RES);
    localparam logic [9:0]  V_LIM     = 10'(V_RES);
    localparam logic [9:0]  X_LAST    = 10'(H_RES - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    // ------------------------------------------------------------------
    // Frame-buffer address: two pixels per 16-bit word
    // ------------------------------------------------------------------
    assign rd_addr = {9'd0, DrawX[9:1]} + ({9'd0, DrawY} * HALF_LINE);

    // ------------------------------------------------------------------
    // Stage 1: pixel context registered alongside the returning rd_data
    // ------------------------------------------------------------------
    logic [9:0]             x1, y1;
    logic                   xlsb1;
    logic                   pv1;
    logic [COLOR_W-1:0]     bike1;
    logic [NUM_PLAYERS-1:0] blocked1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x1       <= '0;
            y1       <= '0;
            xlsb1    <= 1'b0;
            pv1      <= 1'b0;
            bike1    <= '0;
            blocked1 <= '0;
        end else begin
            x1       <= DrawX;
            y1       <= DrawY;
            xlsb1    <= DrawX[0];
            pv1      <= pix_valid;
            bike1    <= bike_color_in;
            blocked1 <= blocked;
        end
    end

    // Even pixels live in the low nibble, odd pixels in bits [11:8]
    logic [COLOR_W-1:0] trail_nib;
    assign trail_nib = xlsb1 ? COLOR_W'(rd_data[11:8]) : COLOR_W'(rd_data[3:0]);

    // ------------------------------------------------------------------
    // Stage 2: priority compositing
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            color_enum    <= TRAIL_EMPTY;
            pix_valid_out <= 1'b0;
        end else begin
            pix_valid_out <= pv1;
            if (!pv1)
                color_enum <= TRAIL_EMPTY;
            else if (|blocked1)
                color_enum <= CRASH_COLOR;
            else if (bike1 != TRANSPARENT)
                color_enum <= bike1;
            else
                color_enum <= trail_nib;
        end
    end

    // ------------------------------------------------------------------
    // frame_clk synchroniser (fsync[1:0]) plus edge-history flop fsync[2]
    // ------------------------------------------------------------------
    logic [2:0] fsync;
    logic       frame_start;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) fsync <= '0;
        else       fsync <= {fsync[1:0], frame_clk};
    end

    assign frame_start = fsync[1] & ~fsync[2];

    // ------------------------------------------------------------------
    // Collision detection against the per-frame head snapshot
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS*10-1:0] snap_x, snap_y;
    logic [NUM_PLAYERS-1:0]    snap_alive;
    logic [NUM_PLAYERS-1:0]    hit, hit_now;
    logic                      last_pix;

    // Off-screen heads are screened out explicitly so that a stray DrawX
    // beyond the visible area can never alias onto them.
    always_comb begin
        hit_now = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            hit_now[p] = pv1 && snap_alive[p]
                         && (trail_nib != TRAIL_EMPTY)
                         && (snap_x[10*p +: 10] < H_LIM)
                         && (snap_y[10*p +: 10] < V_LIM)
                         && (x1 == snap_x[10*p +: 10])
                         && (y1 == snap_y[10*p +: 10]);
        end
    end

    assign last_pix = pv1 && (x1 == X_LAST) && (y1 == Y_LAST);

    state_t state;
    logic   pending;

    // Entering REPORT latches collide (including this cycle's hits) and
    // raises collide_valid, so the pulse coincides with the REPORT cycle.
    // A frame_start seen while scanning is parked in pending so the
    // following REPORT resumes scanning with a fresh snapshot.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            hit           <= '0;
            snap_x        <= '0;
            snap_y        <= '0;
            snap_alive    <= '0;
            collide       <= '0;
            collide_valid <= 1'b0;
        end else begin
            collide_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= SCAN;
                        snap_x     <= head_x;
                        snap_y     <= head_y;
                        snap_alive <= player_alive;
                        hit        <= '0;
                    end
                end
                SCAN: begin
                    hit <= hit | hit_now;
                    if (frame_start || last_pix) begin
                        state         <= REPORT;
                        collide       <= hit | hit_now;
                        collide_valid <= 1'b1;
                        pending       <= pending | frame_start;
                    end
                end
                REPORT: begin
                    if (pending || frame_start) begin
                        state      <= SCAN;
                        pending    <= 1'b0;
                        snap_x     <= head_x;
                        snap_y     <= head_y;
                        snap_alive <= player_alive;
                        hit        <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trail_compositor.sv
// tb_trail_compositor
//   Directed bench for trail_compositor on a reduced 64x48 arena:
//   a vector table for the compositing pipeline, then hand-written frame
//   sequences for collision reporting, truncated frames and mid-frame reset.
module tb_trail_compositor;

    localparam int H = 64;
    localparam int V = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_clk;
    logic [9:0]  draw_x, draw_y;
    logic        pix_valid;
    logic [3:0]  bike;
    logic [19:0] head_x, head_y;
    logic [1:0]  alive, blocked;
    logic [18:0] rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  color_enum;
    logic        pix_valid_out;
    logic [1:0]  collide;
    logic        collide_valid;

    always #5 clk = ~clk;

    trail_compositor #(.NUM_PLAYERS(2), .H_RES(H), .V_RES(V)) dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk),
        .DrawX(draw_x), .DrawY(draw_y), .pix_valid(pix_valid),
        .bike_color_in(bike), .head_x(head_x), .head_y(head_y),
        .player_alive(alive), .blocked(blocked),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .color_enum(color_enum), .pix_valid_out(pix_valid_out),
        .collide(collide), .collide_valid(collide_valid)
    );

    // Frame-buffer model: mode 0 returns 16'h0A03 everywhere, mode 1 holds
    // a single trail nibble 4'h1 (even pixel) at trail_addr.
    int          fb_mode;
    logic [18:0] trail_addr;
    always @(posedge clk)
        rd_data <= (fb_mode == 0) ? 16'h0A03 : ((rd_addr == trail_addr) ? 16'h0001 : 16'h0000);

    int total = 0;
    int bad   = 0;
    int cv_count = 0;
    logic [1:0] last_collide = '0;

    always @(negedge clk)
        if (collide_valid === 1'b1) begin
            cv_count++;
            last_collide = collide;
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        idle(4);
        frame_clk = 1'b0;
        idle(2);
    endtask

    task automatic scan(input int y0, input int y1, input bit fc_at_end);
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < H; x++) begin
                draw_x = 10'(x);
                draw_y = 10'(y);
                pix_valid = 1'b1;
                bike = 4'hF;
                blocked = 2'b00;
                if (fc_at_end && y == y1 && x == H - 1) frame_clk = 1'b1;
                @(posedge clk); #1;
            end
        pix_valid = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  x, y;
        logic        pv;
        logic [3:0]  bike;
        logic [1:0]  blk;
        logic [18:0] exp_addr;
        logic [3:0]  exp_color;
        logic        exp_pv;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{10'd0,   10'd0,  1'b1, 4'hF, 2'b00, 19'd0,    4'h3, 1'b1};
        vecs[1]  = '{10'd1,   10'd0,  1'b1, 4'hF, 2'b00, 19'd0,    4'hA, 1'b1};
        vecs[2]  = '{10'd2,   10'd0,  1'b1, 4'hF, 2'b00, 19'd1,    4'h3, 1'b1};
        vecs[3]  = '{10'd3,   10'd0,  1'b1, 4'hF, 2'b00, 19'd1,    4'hA, 1'b1};
        vecs[4]  = '{10'd4,   10'd0,  1'b1, 4'hF, 2'b00, 19'd2,    4'h3, 1'b1};
        vecs[5]  = '{10'd5,   10'd0,  1'b1, 4'hF, 2'b00, 19'd2,    4'hA, 1'b1};
        vecs[6]  = '{10'd100, 10'd0,  1'b1, 4'h2, 2'b00, 19'd50,   4'h2, 1'b1};
        vecs[7]  = '{10'd100, 10'd0,  1'b1, 4'h2, 2'b10, 19'd50,   4'h7, 1'b1};
        vecs[8]  = '{10'd7,   10'd3,  1'b0, 4'h2, 2'b00, 19'd99,   4'h0, 1'b0};
        vecs[9]  = '{10'd63,  10'd47, 1'b1, 4'hF, 2'b00, 19'd1535, 4'hA, 1'b1};
        vecs[10] = '{10'd1,   10'd1,  1'b1, 4'hF, 2'b01, 19'd32,   4'h7, 1'b1};

        rst = 1'b1; frame_clk = 1'b0; fb_mode = 0; trail_addr = 19'd1305;
        draw_x = '0; draw_y = '0; pix_valid = 1'b0; bike = 4'hF; blocked = '0;
        head_x = {10'd10, 10'd50}; head_y = {10'd10, 10'd40}; alive = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_color", color_enum, 4'h0);
        chk("reset_pv", pix_valid_out, 1'b0);
        chk("reset_collide", collide, 2'b00);
        chk("reset_cv", collide_valid, 1'b0);
        rst = 1'b0;
        idle(2);

        // Compositing pipeline vectors
        for (int i = 0; i < 11; i++) begin
            draw_x = vecs[i].x; draw_y = vecs[i].y; pix_valid = vecs[i].pv;
            bike = vecs[i].bike; blocked = vecs[i].blk;
            #1;
            chk($sformatf("addr[%0d]", i), rd_addr, vecs[i].exp_addr);
            @(posedge clk); @(posedge clk); #1;
            chk($sformatf("color[%0d]", i), color_enum, vecs[i].exp_color);
            chk($sformatf("pvout[%0d]", i), pix_valid_out, vecs[i].exp_pv);
        end
        bike = 4'hF; blocked = 2'b00;
        idle(2);

        // Head 0 on a trail at (50,40)
        fb_mode = 1;
        frame_pulse();
        scan(0, V - 1, 1'b0);
        idle(4);
        chk("hit_cv_count", cv_count, 1);
        chk("hit_collide", last_collide, 2'b01);
        chk("hit_collide_hold", collide, 2'b01);

        // Reset during a scan discards the frame
        frame_pulse();
        scan(0, 29, 1'b0);
        pix_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_color", color_enum, 4'h0);
        chk("midrst_pv", pix_valid_out, 1'b0);
        chk("midrst_collide", collide, 2'b00);
        chk("midrst_cv", collide_valid, 1'b0);
        idle(3);
        rst = 1'b0;
        idle(2);
        scan(0, V - 1, 1'b0);
        idle(4);
        chk("midrst_no_report", cv_count, 1);
        frame_pulse();
        scan(0, V - 1, 1'b0);
        idle(4);
        chk("after_rst_cv", cv_count, 2);
        chk("after_rst_collide", last_collide, 2'b01);

        // Dead player cannot collide
        alive = 2'b10;
        frame_pulse();
        scan(0, V - 1, 1'b0);
        idle(4);
        chk("dead_cv", cv_count, 3);
        chk("dead_collide", last_collide, 2'b00);

        // Off-screen head cannot collide
        alive = 2'b11;
        head_x = {10'd10, 10'd700};
        frame_pulse();
        scan(0, V - 1, 1'b0);
        idle(4);
        chk("offscreen_cv", cv_count, 4);
        chk("offscreen_collide", last_collide, 2'b00);

        // Truncated frame: hit on line 5, new frame_start at line 20
        head_x = {10'd10, 10'd50}; head_y = {10'd10, 10'd5}; trail_addr = 19'd185;
        frame_pulse();
        scan(0, 19, 1'b0);
        head_x = {10'd10, 10'd700}; head_y = {10'd10, 10'd0};
        frame_pulse();
        idle(2);
        chk("trunc_cv", cv_count, 5);
        chk("trunc_collide", last_collide, 2'b01);
        // Restarted scan uses the new (off-screen) snapshot; a frame_start
        // landing in its REPORT cycle must start another scan.
        head_x = {10'd10, 10'd50}; head_y = {10'd10, 10'd5};
        scan(0, V - 1, 1'b1);
        idle(3);
        frame_clk = 1'b0;
        idle(2);
        chk("restart_cv", cv_count, 6);
        chk("restart_collide", last_collide, 2'b00);
        scan(0, V - 1, 1'b0);
        idle(4);
        chk("report_fs_cv", cv_count, 7);
        chk("report_fs_collide", last_collide, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
